// File: rtl/mcu_fft_host_sequencer_if.sv
// Register handshake bundle between the MCU-side host sequencer, the
// upstream sample stream and the ASIC FFT/tone-detect control block.
//   s_valid/s_data/s_ready   : upstream 16-bit valid/ready sample stream
//   asic_status_lsb/msb      : ASIC status register (read by the host)
//   asic_result_lsb/msb      : ASIC tone result (read by the host)
//   mcu_status_lsb/msb       : MCU status register (driven by the host)
//   sample_lsb/msb           : MCU sample-in register (driven by the host)
// master = host sequencer view, slave = stream source / ASIC view.
interface mcu_fft_host_sequencer_if;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [7:0]  asic_status_lsb;
  logic [7:0]  asic_status_msb;
  logic [7:0]  asic_result_lsb;
  logic [7:0]  asic_result_msb;
  logic [7:0]  mcu_status_lsb;
  logic [7:0]  mcu_status_msb;
  logic [7:0]  sample_lsb;
  logic [7:0]  sample_msb;

  modport master (
    input  s_valid, s_data, asic_status_lsb, asic_status_msb,
           asic_result_lsb, asic_result_msb,
    output s_ready, mcu_status_lsb, mcu_status_msb, sample_lsb, sample_msb
  );

  modport slave (
    output s_valid, s_data, asic_status_lsb, asic_status_msb,
           asic_result_lsb, asic_result_msb,
    input  s_ready, mcu_status_lsb, mcu_status_msb, sample_lsb, sample_msb
  );
endinterface

// File: rtl/mcu_fft_host_sequencer.sv
// Host-side master of the ASIC FFT/tone-detect register handshake.
// Pulls N_SAMPLES samples from the upstream stream, hands them one by one to
// the ASIC through the sample-in register, then collects and acknowledges the
// 16-bit tone result. Any wait on the ASIC longer than TIMEOUT_CYCLES lands in
// ERROR with a sticky err flag.
// Ports:
//   clk      : rising-edge clock shared with the ASIC
//   reset_n  : synchronous active-low reset
//   start    : one-cycle frame request, honoured only in IDLE or ERROR
//   pause    : mirrored onto mcu_status_lsb[4] one cycle late while busy
//   bus      : stream + register handshake (master modport)
//   busy     : high in every state except IDLE and ERROR
//   done     : one-cycle pulse when a frame completes
//   tone     : last captured tone result
//   err      : sticky timeout flag, cleared by start or reset
module mcu_fft_host_sequencer #(
  parameter int unsigned N_SAMPLES      = 128,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            pause,
  mcu_fft_host_sequencer_if.master        bus,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     tone,
  output logic                            err
);

  // One extra counter bit so that counter+1 reaching N_SAMPLES never wraps.
  localparam int unsigned CNT_W = $clog2(N_SAMPLES) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1'b1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARM     = 4'd1,
    S_GO      = 4'd2,
    S_FETCH   = 4'd3,
    S_SEND    = 4'd4,
    S_WAITRDY = 4'd5,
    S_WAITRES = 4'd6,
    S_ACK     = 4'd7,
    S_ERROR   = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             sv_q, sv_d;       // mcu[0] sample-valid
  logic             ack_q, ack_d;     // mcu[1] result-ack
  logic             en_q, en_d;       // mcu[2] enable/start
  logic             go_q, go_d;       // mcu[3] stream-go
  logic             pause_q, pause_d; // mcu[4] pause
  logic [15:0]      sample_q, sample_d;
  logic [15:0]      tone_q, tone_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tmo_run;
  logic             tmo_expired;
  logic             asic_rdy;
  logic             asic_rv;
  logic             unused_s;

  assign asic_rdy = bus.asic_status_lsb[3];
  assign asic_rv  = bus.asic_status_lsb[0];
  // all-samples-in, FFT-out busy and the msb register are informational only
  assign unused_s = ^{bus.asic_status_msb, bus.asic_status_lsb[7:4],
                      bus.asic_status_lsb[2:1]};

  // Next-state, handshake bits and all output registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sv_d     = sv_q;
    ack_d    = ack_q;
    en_d     = en_q;
    go_d     = go_q;
    sample_d = sample_q;
    tone_d   = tone_q;
    err_d    = err_q;
    done_d   = 1'b0;
    cnt_inc  = cnt_q + CNT_ONE;
    tmo_run  = (state_q == S_ARM) || (state_q == S_SEND) ||
               (state_q == S_WAITRDY) || (state_q == S_WAITRES) ||
               (state_q == S_ACK);
    tmo_expired = tmo_run && (tmo_q == TMO_LAST);

    if (tmo_expired) begin
      // ASIC stopped answering: drop every status bit and park in ERROR
      state_d = S_ERROR;
      sv_d    = 1'b0;
      ack_d   = 1'b0;
      en_d    = 1'b0;
      go_d    = 1'b0;
      cnt_d   = CNT_ZERO;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_d = S_ARM;
            en_d    = 1'b1;
            err_d   = 1'b0;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = state_q;
          end
        end
        S_ARM: begin
          if (asic_rdy) begin
            state_d = S_GO;
            en_d    = 1'b0;
            go_d    = 1'b1;
          end else begin
            en_d    = 1'b1;
          end
        end
        S_GO: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (bus.s_valid) begin
            sample_d = bus.s_data;
            sv_d     = 1'b1;
            state_d  = S_SEND;
          end else begin
            state_d  = S_FETCH;
          end
        end
        S_SEND: begin
          // ASIC drops sample-ready once it has taken the sample
          if (!asic_rdy) begin
            sv_d  = 1'b0;
            cnt_d = cnt_inc;
            if (cnt_inc < CNT_LAST) begin
              state_d = S_WAITRDY;
            end else begin
              state_d = S_WAITRES;
            end
          end else begin
            state_d = S_SEND;
          end
        end
        S_WAITRDY: begin
          // ready was seen low in SEND, so a high here is a fresh request
          if (asic_rdy) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_WAITRDY;
          end
        end
        S_WAITRES: begin
          if (asic_rv) begin
            tone_d  = {bus.asic_result_msb, bus.asic_result_lsb};
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            state_d = S_WAITRES;
          end
        end
        S_ACK: begin
          if (!asic_rv) begin
            ack_d   = 1'b0;
            go_d    = 1'b0;
            done_d  = 1'b1;
            cnt_d   = CNT_ZERO;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACK;
          end
        end
        default: begin
          state_d = S_IDLE;
          sv_d    = 1'b0;
          ack_d   = 1'b0;
          en_d    = 1'b0;
          go_d    = 1'b0;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Wait budget restarts on every state change
    if (state_d != state_q) begin
      tmo_d = TMO_ZERO;
    end else if (tmo_run) begin
      tmo_d = tmo_q + TMO_ONE;
    end else begin
      tmo_d = tmo_q;
    end

    busy_d    = (state_d != S_IDLE) && (state_d != S_ERROR);
    pause_d   = busy_d && pause;
    s_ready_d = (state_d == S_FETCH);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      tmo_q     <= TMO_ZERO;
      sv_q      <= 1'b0;
      ack_q     <= 1'b0;
      en_q      <= 1'b0;
      go_q      <= 1'b0;
      pause_q   <= 1'b0;
      sample_q  <= 16'h0000;
      tone_q    <= 16'h0000;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      sv_q      <= sv_d;
      ack_q     <= ack_d;
      en_q      <= en_d;
      go_q      <= go_d;
      pause_q   <= pause_d;
      sample_q  <= sample_d;
      tone_q    <= tone_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.mcu_status_lsb = {3'b000, pause_q, go_q, en_q, ack_q, sv_q};
  assign bus.mcu_status_msb = 8'h00;
  assign bus.sample_lsb     = sample_q[7:0];
  assign bus.sample_msb     = sample_q[15:8];
  assign bus.s_ready        = s_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign tone               = tone_q;
  assign err                = err_q;

endmodule

// File: tb/tb_mcu_fft_host_sequencer.sv
`timescale 1ns/1ps
// Directed bench for mcu_fft_host_sequencer: a small ASIC/stream model runs
// on the falling edge, the main sequence drives start/pause/result and checks
// registered outputs 1 ns after each rising edge.
module tb_mcu_fft_host_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        pause;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] tone;
  logic        asic_rdy;
  logic        asic_rv;

  int          total = 0;
  int          bad = 0;
  logic [15:0] got[$];
  int          done_cnt;
  int          stall_rdy_cnt;
  int          src_idx;
  int          clear_seq = 0;
  int          stall_at_cfg = -1;
  int          stall_len_cfg = 0;
  int          hang_at_cfg = 0;

  mcu_fft_host_sequencer_if bus_if();

  assign bus_if.asic_status_lsb = {4'b0000, asic_rdy, 2'b00, asic_rv};
  assign bus_if.asic_status_msb = 8'h00;

  always #5 clk = ~clk;

  mcu_fft_host_sequencer #(.N_SAMPLES(128), .TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .pause   (pause),
    .bus     (bus_if),
    .busy    (busy),
    .done    (done),
    .tone    (tone),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    int i;
    i = 0;
    while (got.size() < n && i < 3000) begin
      tick();
      i++;
    end
    chk(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    int i;
    i = 0;
    while (bus_if.mcu_status_lsb[1] !== 1'b1 && i < 100) begin
      tick();
      i++;
    end
    chk(tag, 32'(bus_if.mcu_status_lsb[1]), 32'd1);
  endtask

  task automatic check_order(input int first, input int n, input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= got.size() || got[i] !== 16'(first + i)) mism++;
    end
    chk(tag, 32'(mism), 32'd0);
  endtask

  // ASIC and upstream-stream model, evaluated on the falling edge
  initial begin : asic_model
    int   last_seq;
    int   rr;
    int   stall_left;
    logic sv_prev;
    last_seq = 0; rr = 0; stall_left = 0; sv_prev = 1'b0;
    asic_rdy = 1'b0; src_idx = 0; done_cnt = 0; stall_rdy_cnt = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (clear_seq != last_seq) begin
        last_seq = clear_seq;
        got.delete();
        rr = 0; stall_left = stall_len_cfg; sv_prev = 1'b0;
        asic_rdy = 1'b0; src_idx = 0; done_cnt = 0; stall_rdy_cnt = 0;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 16'h0000;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (bus_if.mcu_status_lsb[2] === 1'b1 && !asic_rdy) asic_rdy = 1'b1;
        if (bus_if.mcu_status_lsb[0] === 1'b1 && !sv_prev) begin
          got.push_back({bus_if.sample_msb, bus_if.sample_lsb});
          src_idx++;
          bus_if.s_data = 16'(src_idx);
          if (got.size() != hang_at_cfg) begin
            asic_rdy = 1'b0;
            rr = 3;
          end
        end else if (rr > 0) begin
          rr--;
          if (rr == 0) asic_rdy = 1'b1;
        end
        if (src_idx == stall_at_cfg && stall_left > 0) begin
          bus_if.s_valid = 1'b0;
          stall_left--;
          if (bus_if.s_ready === 1'b1) stall_rdy_cnt++;
        end else begin
          bus_if.s_valid = 1'b1;
        end
        sv_prev = bus_if.mcu_status_lsb[0];
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin : main_seq
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; asic_rv = 1'b0;
    bus_if.asic_result_lsb = 8'h00;
    bus_if.asic_result_msb = 8'h00;
    tick();
    tick();
    chk("rst_mcu_lsb", 32'(bus_if.mcu_status_lsb), 32'h00);
    chk("rst_mcu_msb", 32'(bus_if.mcu_status_msb), 32'h00);
    chk("rst_sample", 32'({bus_if.sample_msb, bus_if.sample_lsb}), 32'h0000);
    chk("rst_flags", 32'({busy, done, err, bus_if.s_ready}), 32'h0);
    chk("rst_tone", 32'(tone), 32'h0000);
    reset_n = 1'b1;
    clear_seq++;
    tick();

    // Nominal frame
    pulse_start();
    chk("arm_status", 32'(bus_if.mcu_status_lsb), 32'h04);
    chk("arm_busy", 32'(busy), 32'd1);
    tick();
    chk("go_status", 32'(bus_if.mcu_status_lsb), 32'h08);
    tick();
    chk("fetch_ready", 32'(bus_if.s_ready), 32'd1);
    tick();
    chk("first_send_status", 32'(bus_if.mcu_status_lsb), 32'h09);
    chk("first_send_data", 32'({bus_if.sample_msb, bus_if.sample_lsb}), 32'h0000);
    chk("send_not_ready", 32'(bus_if.s_ready), 32'd0);
    wait_got(128, "f1_samples");
    bus_if.asic_result_lsb = 8'h34;
    bus_if.asic_result_msb = 8'h12;
    asic_rv = 1'b1;
    wait_ack("f1_ack");
    chk("f1_tone", 32'(tone), 32'h1234);
    chk("f1_ack_status", 32'(bus_if.mcu_status_lsb), 32'h0A);
    asic_rv = 1'b0;
    tick();
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_end_status", 32'(bus_if.mcu_status_lsb), 32'h00);
    chk("f1_busy_low", 32'(busy), 32'd0);
    tick();
    chk("f1_done_pulse", 32'(done), 32'd0);
    check_order(0, 128, "f1_order");
    chk("f1_count", 32'(got.size()), 32'd128);
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);

    // Stall before sample 64, pause mid-frame, start while busy, long ack
    stall_at_cfg = 64;
    stall_len_cfg = 50;
    clear_seq++;
    tick();
    pulse_start();
    wait_got(20, "f2_reach20");
    pause = 1'b1;
    chk("pause_before", 32'(bus_if.mcu_status_lsb[4]), 32'd0);
    tick();
    chk("pause_on", 32'(bus_if.mcu_status_lsb[4]), 32'd1);
    repeat (19) tick();
    pause = 1'b0;
    chk("pause_held", 32'(bus_if.mcu_status_lsb[4]), 32'd1);
    tick();
    chk("pause_off", 32'(bus_if.mcu_status_lsb[4]), 32'd0);
    wait_got(30, "f2_reach30");
    pulse_start();
    chk("start_ignored_en", 32'(bus_if.mcu_status_lsb[2]), 32'd0);
    chk("start_ignored_busy", 32'(busy), 32'd1);
    wait_got(128, "f2_samples");
    asic_rv = 1'b1;
    wait_ack("f2_ack");
    for (int i = 0; i < 10; i++) begin
      chk("f2_ack_hold", 32'({bus_if.mcu_status_lsb[1], done}), 32'h2);
      tick();
    end
    asic_rv = 1'b0;
    tick();
    chk("f2_done", 32'(done), 32'd1);
    chk("f2_ack_clear", 32'(bus_if.mcu_status_lsb[1]), 32'd0);
    chk("f2_tone", 32'(tone), 32'h1234);
    tick();
    chk("f2_done_pulse", 32'(done), 32'd0);
    check_order(0, 128, "f2_order");
    chk("f2_count", 32'(got.size()), 32'd128);
    chk("f2_stall_ready", 32'(stall_rdy_cnt), 32'd46);
    chk("f2_err", 32'(err), 32'd0);
    chk("f2_done_cnt", 32'(done_cnt), 32'd1);

    // Timeout: ASIC keeps sample-ready high after sample 5
    stall_at_cfg = -1;
    stall_len_cfg = 0;
    hang_at_cfg = 6;
    clear_seq++;
    tick();
    pulse_start();
    wait_got(6, "f3_reach6");
    repeat (14) tick();
    chk("tmo_pending_err", 32'(err), 32'd0);
    chk("tmo_pending_status", 32'(bus_if.mcu_status_lsb), 32'h09);
    chk("tmo_pending_data", 32'({bus_if.sample_msb, bus_if.sample_lsb}), 32'h0005);
    tick();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_status", 32'(bus_if.mcu_status_lsb), 32'h00);
    chk("tmo_busy", 32'(busy), 32'd0);
    pause = 1'b1;
    tick();
    tick();
    chk("err_pause_masked", 32'(bus_if.mcu_status_lsb), 32'h00);
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_tone_held", 32'(tone), 32'h1234);
    pause = 1'b0;
    pulse_start();
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_status", 32'(bus_if.mcu_status_lsb), 32'h04);
    chk("restart_busy", 32'(busy), 32'd1);

    // Reset mid-frame, then a clean full frame
    wait_got(40, "f4_reach40");
    reset_n = 1'b0;
    tick();
    chk("mid_rst_status", 32'(bus_if.mcu_status_lsb), 32'h00);
    chk("mid_rst_sample", 32'({bus_if.sample_msb, bus_if.sample_lsb}), 32'h0000);
    chk("mid_rst_flags", 32'({busy, done, err, bus_if.s_ready}), 32'h0);
    chk("mid_rst_tone", 32'(tone), 32'h0000);
    reset_n = 1'b1;
    hang_at_cfg = 0;
    clear_seq++;
    tick();
    pulse_start();
    wait_got(128, "f5_samples");
    bus_if.asic_result_lsb = 8'h3C;
    bus_if.asic_result_msb = 8'h5A;
    asic_rv = 1'b1;
    wait_ack("f5_ack");
    chk("f5_tone", 32'(tone), 32'h5A3C);
    asic_rv = 1'b0;
    tick();
    chk("f5_done", 32'(done), 32'd1);
    tick();
    check_order(0, 128, "f5_order");
    chk("f5_count", 32'(got.size()), 32'd128);
    chk("f5_done_cnt", 32'(done_cnt), 32'd1);
    chk("f5_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
